// File: rtl/uart_tx_fifo.sv
// Byte UART transmitter (8N1, LSB first) fed by a small circular write FIFO.
// Tx_Ready paces the upstream writer; Overflow latches any dropped write.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [7:0] Word_To_Send,
  input  logic       TX_Write_en,
  input  logic       TX_en,
  output logic       RsTx,
  output logic       Tx_Ready,
  output logic       Tx_Busy,
  output logic       Overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ready_q;
  logic              ovf_q;

  state_e            state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_idx_q;
  logic [BAUD_W-1:0] baud_q;
  logic              rstx_q;
  logic              busy_q;

  logic full_c;
  logic wr_acc_c;
  logic pop_c;
  logic baud_end_c;

  // Acceptance and pop decisions use pre-edge count only.
  assign full_c     = (count_q == DEPTH_C);
  assign wr_acc_c   = TX_Write_en && !full_c;
  assign pop_c      = (state_q == IDLE) && (count_q != '0) && TX_en;
  assign baud_end_c = (baud_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    case ({wr_acc_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= Word_To_Send;
    end
  end

  // FIFO bookkeeping, Tx_Ready and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d < DEPTH_C);
      if (TX_Write_en && full_c) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Serializer: the baud counter restarts on every state change.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      rstx_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rstx_q <= 1'b1;
          busy_q <= 1'b0;
          if (pop_c) begin
            shift_q   <= mem_q[rd_ptr_q];
            bit_idx_q <= '0;
            baud_q    <= '0;
            rstx_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (baud_end_c) begin
            baud_q  <= '0;
            rstx_q  <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end_c) begin
            baud_q    <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              rstx_q  <= 1'b1;
              state_q <= STOP;
            end else begin
              rstx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end_c) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          rstx_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign RsTx     = rstx_q;
  assign Tx_Ready = ready_q;
  assign Tx_Busy  = busy_q;
  assign Overflow = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-oriented UART transmitter with a small write FIFO. It sits directly downstream of the command reader: it accepts `Word_To_Send` bytes on `TX_Write_en` strobes, buffers them, and serializes them 8N1, LSB first, on `RsTx`. It reports `Tx_Ready` back so the command reader can pace its writes.

## Interface
- `CLKS_PER_BIT`, default 868: clocks per UART bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_b`  in  1  reset. The codebase port name is kept, but this reset is **asynchronous and active-high**: `reset_b` = 1 resets the block.
- `Word_To_Send`  in  8  byte to enqueue; sampled only when `TX_Write_en` = 1.
- `TX_Write_en`  in  1  single-cycle write strobe. A strobe held high for N cycles writes N bytes.
- `TX_en`  in  1  transmit enable. When 0, no new frame starts; a frame already in progress completes.
- `RsTx`  out  1  serial line, registered; idles high.
- `Tx_Ready`  out  1  1 when FIFO count < `FIFO_DEPTH`, registered from count.
- `Tx_Busy`  out  1  1 while the serializer is in any state other than IDLE.
- `Overflow`  out  1  sticky; set when a write is dropped; cleared only by reset.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers of log2(`FIFO_DEPTH`) bits; pointers wrap naturally.
  - Count is log2(`FIFO_DEPTH`)+1 bits.
- **Write acceptance**
  - A write is accepted iff `TX_Write_en` = 1 and count < `FIFO_DEPTH`, both evaluated before the edge.
  - A write when full is dropped and sets `Overflow`, even if a pop occurs on the same edge.
- **Count update**: +1 on accepted write, −1 on pop, unchanged when both happen on the same edge.
- **Serializer FSM**: IDLE, START, DATA, STOP.
  - IDLE: `RsTx` = 1. If count > 0 and `TX_en` = 1, pop the head into an 8-bit shift register, clear the bit counter and baud counter, go to START.
  - START: `RsTx` = 0 for `CLKS_PER_BIT` clocks, then go to DATA.
  - DATA: `RsTx` = shift[0]. Each bit lasts `CLKS_PER_BIT` clocks. At the end of each bit, shift right and increment the 3-bit bit index. After bit 7, go to STOP.
  - STOP: `RsTx` = 1 for `CLKS_PER_BIT` clocks, then go to IDLE.
- **Baud counter**: counts 0..`CLKS_PER_BIT`−1 and is cleared on every state change.
- **`TX_en` changes**: deassertion mid-frame has no effect on the current frame. Reassertion resumes from IDLE with FIFO contents intact.
- **Empty FIFO**: remain in IDLE with the line high. Pop is never attempted when count = 0.
- **Reset** (asynchronous, including mid-frame): FSM → IDLE, pointers and count → 0, `RsTx` = 1, `Tx_Ready` = 1, `Tx_Busy` = 0, `Overflow` = 0. A partially sent frame is abandoned and buffered data is lost.

## Timing
- Reset values: `RsTx` 1, `Tx_Ready` 1, `Tx_Busy` 0, `Overflow` 0.
- **Write-to-line latency** (FIFO empty, IDLE, `TX_en` = 1):
  - Write sampled at edge k; count = 1 after edge k.
  - Pop at edge k+1; `RsTx` = 0 and `Tx_Busy` = 1 after edge k+1.
- **Frame length**: 10 × `CLKS_PER_BIT` clocks from the start-bit falling edge to the end of the stop bit.
- **Back-to-back frames**: IDLE is occupied for exactly one clock between frames. The next start bit therefore begins 10 × `CLKS_PER_BIT` + 1 clocks after the previous one.
- **`Tx_Ready`**
  - Falls after the edge at which count reaches `FIFO_DEPTH`.
  - Rises after the edge of the pop that frees a slot.
  - The writer must treat a strobe while `Tx_Ready` = 0 as dropped.
- **`Overflow`**: set after the edge of the dropped write.
- **`Tx_Busy`**: drops after the edge leaving STOP.

## Test plan
Benches use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.

1. **Single byte.** Reset, then `TX_en` = 1 and write 0xA5 once.
   - `RsTx` falls 2 edges after the write.
   - Line sequence, 4 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1.
   - `Tx_Busy` high for 40 clocks; line high afterwards.
2. **Fill and overflow.** `TX_en` = 0, write 0x01, 0x02, 0x03, 0x04, then 0x05.
   - `Tx_Ready` = 0 after the 4th write.
   - 0x05 is dropped and `Overflow` = 1.
   - Then set `TX_en` = 1: exactly 0x01..0x04 are sent in order, with 41-clock start-to-start spacing. `Tx_Ready` returns to 1 after the first pop.
3. **Full FIFO with concurrent pop and write.** At the edge where IDLE pops from the full FIFO, also strobe 0x55.
   - 0x55 is dropped and `Overflow` = 1.
   - Count becomes 3.
4. **`TX_en` drop mid-frame.** Queue 0x3C and 0xC3, then drop `TX_en` during the DATA bits of 0x3C.
   - 0x3C completes.
   - 0xC3 is held and the line stays high.
   - Reassert `TX_en`: 0xC3 is sent.
5. **Reset mid-frame.** Assert `reset_b` = 1 during bit 3 of 0xFF with two bytes queued.
   - `RsTx` = 1 immediately, without waiting for a clock edge.
   - After release: count 0, `Tx_Ready` 1, `Overflow` 0, and no further frames.
6. **Sustained writes.** Write a strobe every 41 clocks for 20 bytes (0x00..0x13).
   - Continuous back-to-back frames.
   - `Overflow` stays 0.
   - Decoded stream matches the written stream.
